// File: rtl/blockmem_arb_pkg.sv
// Shared types for the single-port block memory arbiter.
// BLOCKMEM_ARB_OUTREG_EN adds one output register stage to the read return path.
package blockmem_arb_pkg;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_sel_t;

  typedef struct packed {
    logic      valid;
    port_sel_t port;
  } rd_tag_t;

`ifdef BLOCKMEM_ARB_OUTREG_EN
  localparam int C_RD_LATENCY = 2;
`else
  localparam int C_RD_LATENCY = 1;
`endif

  function automatic port_sel_t other_port(input port_sel_t p);
    return (p == PORT0) ? PORT1 : PORT0;
  endfunction

endpackage

// File: rtl/blockmem_arb_rr.sv
// Round-robin grant logic with bounded burst hold for two requesters.
// Holds the last-granted pointer and the consecutive-grant counter; no datapath.
module blockmem_arb_rr
  import blockmem_arb_pkg::*;
#(
  parameter int G_MAXBURST = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      s0_req,
  input  logic      s1_req,
  output logic      s0_gnt,
  output logic      s1_gnt,
  output port_sel_t gnt_port
);

  localparam int C_CNTW = $clog2(G_MAXBURST + 1);
  localparam logic [C_CNTW-1:0] C_MAX = C_CNTW'(G_MAXBURST);

  port_sel_t         last_q;
  port_sel_t         sel;
  logic [C_CNTW-1:0] burst_q;
  logic [C_CNTW-1:0] burst_d;
  logic              any_gnt;

  // Counter saturates at C_MAX so a long solo run still forces a switch on contention.
  always_comb begin
    sel = other_port(last_q);
    if (s0_req && !s1_req)
      sel = PORT0;
    else if (s1_req && !s0_req)
      sel = PORT1;
    else if (burst_q != '0 && burst_q != C_MAX)
      sel = last_q;

    any_gnt  = (s0_req | s1_req) & ~rst;
    s0_gnt   = any_gnt & (sel == PORT0);
    s1_gnt   = any_gnt & (sel == PORT1);
    gnt_port = sel;

    burst_d = '0;
    if (any_gnt) begin
      if (sel != last_q)
        burst_d = C_CNTW'(1);
      else if (burst_q != C_MAX)
        burst_d = burst_q + 1'b1;
      else
        burst_d = burst_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q  <= PORT1;
      burst_q <= '0;
    end else begin
      if (any_gnt)
        last_q <= sel;
      burst_q <= burst_d;
    end
  end

endmodule

// File: rtl/blockmem_1p_arbiter.sv
// Shares one single-port block memory between two requesters; routes read data by tag.
// BLOCKMEM_ARB_OUTREG_EN registers rdata/rvalid one extra stage (read latency 2).
module blockmem_1p_arbiter
  import blockmem_arb_pkg::*;
#(
  parameter int G_DATAWIDTH = 32,
  parameter int G_MEMDEPTH  = 1024,
  parameter int G_BWENABLE  = 0,
  parameter int G_ADDRWIDTH = $clog2(G_MEMDEPTH),
  parameter int G_WEWIDTH   = ((((G_DATAWIDTH + 7) & ~7) - 1) / 8) * G_BWENABLE + 1,
  parameter int G_MAXBURST  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s0_req,
  input  logic [G_WEWIDTH-1:0]   s0_we,
  input  logic [G_ADDRWIDTH-1:0] s0_addr,
  input  logic [G_DATAWIDTH-1:0] s0_wdata,
  output logic                   s0_gnt,
  output logic                   s0_rvalid,
  output logic [G_DATAWIDTH-1:0] s0_rdata,
  input  logic                   s1_req,
  input  logic [G_WEWIDTH-1:0]   s1_we,
  input  logic [G_ADDRWIDTH-1:0] s1_addr,
  input  logic [G_DATAWIDTH-1:0] s1_wdata,
  output logic                   s1_gnt,
  output logic                   s1_rvalid,
  output logic [G_DATAWIDTH-1:0] s1_rdata,
  output logic                   mem_ena,
  output logic [G_WEWIDTH-1:0]   mem_wea,
  output logic [G_ADDRWIDTH-1:0] mem_addra,
  output logic [G_DATAWIDTH-1:0] mem_dina,
  input  logic [G_DATAWIDTH-1:0] mem_douta
);

  port_sel_t gnt_port;
  rd_tag_t   tag_issue;
  rd_tag_t   tag_pipe [C_RD_LATENCY];
  rd_tag_t   tag_ret;

  blockmem_arb_rr #(
    .G_MAXBURST(G_MAXBURST)
  ) u_rr (
    .clk     (clk),
    .rst     (rst),
    .s0_req  (s0_req),
    .s1_req  (s1_req),
    .s0_gnt  (s0_gnt),
    .s1_gnt  (s1_gnt),
    .gnt_port(gnt_port)
  );

  always_comb begin
    mem_ena   = s0_gnt | s1_gnt;
    mem_wea   = '0;
    mem_addra = '0;
    mem_dina  = '0;
    if (s0_gnt) begin
      mem_wea   = s0_we;
      mem_addra = s0_addr;
      mem_dina  = s0_wdata;
    end else if (s1_gnt) begin
      mem_wea   = s1_we;
      mem_addra = s1_addr;
      mem_dina  = s1_wdata;
    end
    tag_issue.valid = mem_ena & ~|mem_wea;
    tag_issue.port  = gnt_port;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < C_RD_LATENCY; i++)
        tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= tag_issue;
      for (int i = 1; i < C_RD_LATENCY; i++)
        tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign tag_ret   = tag_pipe[C_RD_LATENCY-1];
  // Gating with rst drops a tag that was issued just before reset asserted.
  assign s0_rvalid = tag_ret.valid & (tag_ret.port == PORT0) & ~rst;
  assign s1_rvalid = tag_ret.valid & (tag_ret.port == PORT1) & ~rst;

`ifdef BLOCKMEM_ARB_OUTREG_EN
  logic [G_DATAWIDTH-1:0] s0_rdata_q;
  logic [G_DATAWIDTH-1:0] s1_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_rdata_q <= '0;
      s1_rdata_q <= '0;
    end else begin
      if (tag_pipe[0].valid && tag_pipe[0].port == PORT0)
        s0_rdata_q <= mem_douta;
      if (tag_pipe[0].valid && tag_pipe[0].port == PORT1)
        s1_rdata_q <= mem_douta;
    end
  end

  assign s0_rdata = s0_rdata_q;
  assign s1_rdata = s1_rdata_q;
`else
  logic [G_DATAWIDTH-1:0] s0_hold_q;
  logic [G_DATAWIDTH-1:0] s1_hold_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_hold_q <= '0;
      s1_hold_q <= '0;
    end else begin
      if (s0_rvalid)
        s0_hold_q <= mem_douta;
      if (s1_rvalid)
        s1_hold_q <= mem_douta;
    end
  end

  assign s0_rdata = s0_rvalid ? mem_douta : s0_hold_q;
  assign s1_rdata = s1_rvalid ? mem_douta : s1_hold_q;
`endif

endmodule
